// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: scan states and the
// active-low hex glyph table, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

   typedef enum logic {
      ST_BLANK,
      ST_SHOW
   } scan_state_e;

   localparam logic [3:0] AN_OFF  = 4'hF;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Index 0 holds the glyph for hex 0, index 15 the glyph for hex F.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/sevenseg_scanner.sv
// Four-digit multiplexed seven-segment driver: each digit is preceded by an
// all-off gap, and the whole frame shows one snapshot of the input value.
module sevenseg_scanner
   import seg_pkg::*;
#(
   parameter int REFRESH_CYCLES = 100_000,
   parameter int BLANK_CYCLES   = 1_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int MAX_CYCLES = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   scan_state_e      state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      snap_q, snap_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             tick_q, tick_d;

   logic [3:0]       curNibble;
   logic [6:0]       curPattern;
   logic             lastCycle;
   logic             digitOn;

   assign curNibble = snap_q[{idx_q, 2'b00} +: 4];

   hex_to_seg u_hex_to_seg (
      .hex_i (curNibble),
      .seg_o (curPattern)
   );

   // Snapshot is taken only at the very start of a frame so all four digits agree.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q + 1'b1;
      snap_d    = snap_q;
      tick_d    = 1'b0;
      lastCycle = (state_q == ST_BLANK) ? (cnt_q == CNT_W'(BLANK_CYCLES - 1))
                                        : (cnt_q == CNT_W'(REFRESH_CYCLES - 1));
      if (state_q == ST_BLANK && cnt_q == '0 && idx_q == 2'd0) begin
         snap_d = value;
      end
      if (lastCycle) begin
         cnt_d = '0;
         if (state_q == ST_BLANK) begin
            state_d = ST_SHOW;
         end else begin
            state_d = ST_BLANK;
            idx_d   = idx_q + 2'd1;
            tick_d  = (idx_q == 2'd3);
         end
      end
   end

   always_comb begin
      an_d    = AN_OFF;
      seg_d   = SEG_OFF;
      dp_d    = 1'b1;
      digitOn = (state_q == ST_SHOW) && !blank[idx_q];
      if (digitOn) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = curPattern;
         dp_d  = ~dp_in[idx_q];
      end
   end

   // Outputs are derived from the current state only, so at most one anode is ever low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_BLANK;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         snap_q  <= 16'h0000;
         an_q    <= AN_OFF;
         seg_q   <= SEG_OFF;
         dp_q    <= 1'b1;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         tick_q  <= tick_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_tick = tick_q;

endmodule
